// File: rtl/megaram_mem_seq.sv
// Memory sequencer behind the MegaRAM/SCC mapper: one request/ack handshake
// per cartridge bus cycle, with Z80 WAIT held until the memory answers.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for an armed read or RAM-mode write strobe
// S_WAIT_ACK | mem_req held, waiting for mem_ack or timeout
// S_RELEASE  | WAIT released, read data driven until the strobes rise
module megaram_mem_seq #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              cart_ena,
    input  logic              ram_ena,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [7:0]        cdin,
    output logic [7:0]        cdout,
    output logic              cdout_oe,
    output logic              wait_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_RELEASE
    } state_t;

    localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        cdout_q, cdout_d;
    logic              cdout_oe_q, cdout_oe_d;
    logic              wait_n_q, wait_n_d;
    logic              timeout_err_q, timeout_err_d;
    logic              armed_q, armed_d;
    logic              ended_q, ended_d;
    logic [9:0]        cnt_q, cnt_d;

    logic       rd_go;
    logic       wr_go;
    logic       strobes_idle;
    logic [9:0] cnt_inc;

    assign strobes_idle = rd_n & wr_n;
    assign rd_go        = cart_ena & ~rd_n & armed_q;
    assign wr_go        = cart_ena & ~wr_n & ram_ena & armed_q;
    assign cnt_inc      = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_a_d       = mem_a_q;
        mem_wdata_d   = mem_wdata_q;
        cdout_d       = cdout_q;
        cdout_oe_d    = cdout_oe_q;
        wait_n_d      = wait_n_q;
        timeout_err_d = timeout_err_q;
        armed_d       = armed_q;
        ended_d       = ended_q;
        cnt_d         = cnt_q;

        // One transaction per bus cycle: disarm on any cartridge strobe,
        // re-arm only once both strobes are back high.
        if (cart_ena && (!rd_n || !wr_n)) begin
            armed_d = 1'b0;
        end else if (strobes_idle) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_go || wr_go) begin
                    state_d     = S_WAIT_ACK;
                    mem_req_d   = 1'b1;
                    wait_n_d    = 1'b0;
                    mem_a_d     = mem_addr;
                    mem_wdata_d = cdin;
                    mem_we_d    = ~rd_go;
                    cnt_d       = 10'd0;
                    ended_d     = 1'b0;
                end
            end
            S_WAIT_ACK: begin
                // The bus cycle may finish early; the request still completes
                // but any read data is thrown away.
                ended_d = ended_q | strobes_idle;
                cnt_d   = cnt_inc;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RELEASE;
                    if (!mem_we_q && !ended_d) begin
                        cdout_d = mem_rdata;
                    end
                end else if (cnt_inc >= TO_LIM) begin
                    mem_req_d     = 1'b0;
                    cdout_d       = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end
            end
            S_RELEASE: begin
                wait_n_d   = 1'b1;
                cdout_oe_d = ~mem_we_q & ~ended_q & ~rd_n & cart_ena;
                if (strobes_idle) begin
                    state_d    = S_IDLE;
                    cdout_oe_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_a_q       <= '0;
            mem_wdata_q   <= 8'h00;
            cdout_q       <= 8'hFF;
            cdout_oe_q    <= 1'b0;
            wait_n_q      <= 1'b1;
            timeout_err_q <= 1'b0;
            armed_q       <= 1'b1;
            ended_q       <= 1'b0;
            cnt_q         <= 10'd0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_a_q       <= mem_a_d;
            mem_wdata_q   <= mem_wdata_d;
            cdout_q       <= cdout_d;
            cdout_oe_q    <= cdout_oe_d;
            wait_n_q      <= wait_n_d;
            timeout_err_q <= timeout_err_d;
            armed_q       <= armed_d;
            ended_q       <= ended_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cdout       = cdout_q;
    assign cdout_oe    = cdout_oe_q;
    assign wait_n      = wait_n_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_a       = mem_a_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_megaram_mem_seq.sv
// Bench for megaram_mem_seq: bus-cycle stimulus, memory responder, and a
// monitor that checks requests, WAIT length and read data against queues.
module tb_megaram_mem_seq;

    localparam int ADDR_W  = 23;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic              cart_ena = 1'b0;
    logic              ram_ena = 1'b0;
    logic              rd_n = 1'b1;
    logic              wr_n = 1'b1;
    logic [7:0]        cdin = 8'h00;
    logic [7:0]        cdout;
    logic              cdout_oe;
    logic              wait_n;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_ack = 1'b0;
    logic              timeout_err;

    megaram_mem_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .cart_ena(cart_ena),
        .ram_ena(ram_ena), .rd_n(rd_n), .wr_n(wr_n), .cdin(cdin),
        .cdout(cdout), .cdout_oe(cdout_oe), .wait_n(wait_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [7:0]        d;
        int                len;
    } txn_t;

    txn_t       txn_q[$];
    logic [7:0] data_q[$];
    logic [7:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [7:0] phys_mem [logic [ADDR_W-1:0]];

    int errors = 0;
    int checks = 0;
    int exp_reqs = 0;
    int req_rises = 0;
    bit sb_flush = 1'b1;
    bit resp_en = 1'b1;
    int cur_dly = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] phys_rd(input logic [ADDR_W-1:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    // Memory controller model: acks cur_dly negedges after seeing mem_req.
    initial begin
        int  cnt;
        bit  acked;
        cnt = 0;
        acked = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mem_ack = 1'b0;
                if (mem_req && !acked) begin
                    cnt++;
                    if (cur_dly != 0 && cnt == cur_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = phys_rd(mem_a);
                        if (mem_we) phys_mem[mem_a] = mem_wdata;
                        acked = 1'b1;
                    end
                end
                if (!mem_req) begin
                    cnt = 0;
                    acked = 1'b0;
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        logic prev_req, prev_wait, prev_oe;
        int   req_len, cur_len, wait_low, exp_wait;
        txn_t t;
        logic [7:0] ed;
        prev_req = 1'b0; prev_wait = 1'b1; prev_oe = 1'b0;
        req_len = 0; cur_len = 0; wait_low = 0; exp_wait = -1;
        forever begin
            @(negedge clk);
            if (sb_flush) begin
                req_len = 0; wait_low = 0; exp_wait = -1;
                data_q.delete();
            end else begin
                if (mem_req && !prev_req) begin
                    req_rises++;
                    if (txn_q.size() == 0) begin
                        chk("unexpected_req", 32'(mem_a), 32'h0DEAD);
                    end else begin
                        t = txn_q.pop_front();
                        chk("mem_a", 32'(mem_a), 32'(t.a));
                        chk("mem_we", 32'(mem_we), 32'(t.we));
                        chk("mem_wdata", 32'(mem_wdata), 32'(t.d));
                        cur_len = t.len;
                        exp_wait = t.len + 1;
                    end
                    req_len = 1;
                end else if (mem_req) begin
                    req_len++;
                end else if (prev_req) begin
                    chk("req_len", 32'(req_len), 32'(cur_len));
                end
                if (!wait_n) wait_low++;
                if (wait_n && !prev_wait) begin
                    if (exp_wait < 0) chk("unexpected_wait", 32'(wait_low), 32'h0);
                    else chk("wait_len", 32'(wait_low), 32'(exp_wait));
                    wait_low = 0;
                    exp_wait = -1;
                end
                if (cdout_oe && !prev_oe) begin
                    if (data_q.size() == 0) begin
                        chk("unexpected_oe", 32'(cdout), 32'h0DEAD);
                    end else begin
                        ed = data_q.pop_front();
                        chk("cdout", 32'(cdout), 32'(ed));
                    end
                end
            end
            prev_req = mem_req;
            prev_wait = wait_n;
            prev_oe = cdout_oe;
        end
    end

    // kind: 0 read, 1 write, 2 both strobes low (read must win).
    task automatic bus_cycle(input int kind, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                             input bit ram, input int dly, input bit early, input int hold);
        bit is_rd, expect_txn, seen, done;
        txn_t t;
        is_rd = (kind != 1);
        expect_txn = is_rd || ram;
        cur_dly = dly;
        if (expect_txn) begin
            t.a = a; t.we = ~is_rd; t.d = d;
            t.len = (dly == 0) ? TIMEOUT : dly;
            txn_q.push_back(t);
            exp_reqs++;
            if (is_rd && !early) data_q.push_back((dly == 0) ? 8'hFF : ref_rd(a));
            if (!is_rd) ref_mem[a] = d;
        end
        @(posedge clk); #1;
        cart_ena = 1'b1; ram_ena = ram; mem_addr = a; cdin = d;
        rd_n = (kind == 1);
        wr_n = (kind == 0);
        if (expect_txn) begin
            seen = 1'b0; done = 1'b0;
            for (int i = 0; i < 64 && !done; i++) begin
                @(posedge clk); #1;
                if (early && i == 1) begin rd_n = 1'b1; wr_n = 1'b1; end
                if (!wait_n) seen = 1'b1;
                else if (seen) done = 1'b1;
            end
            if (!done) chk("wait_release_bound", 32'(done), 32'h1);
        end else begin
            repeat (3) begin @(posedge clk); #1; end
        end
        repeat (hold) begin @(posedge clk); #1; end
        rd_n = 1'b1; wr_n = 1'b1; cart_ena = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("oe_after_cycle", 32'(cdout_oe), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_wait_n", 32'(wait_n), 32'h1);
        chk("rst_cdout", 32'(cdout), 32'hFF);
        chk("rst_cdout_oe", 32'(cdout_oe), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_mem_a", 32'(mem_a), 32'h0);
        sb_flush = 1'b0;

        ref_mem[23'h420123] = 8'h5A;
        phys_mem[23'h420123] = 8'h5A;
        bus_cycle(0, 23'h420123, 8'h00, 1'b1, 3, 1'b0, 2);
        bus_cycle(1, 23'h001234, 8'hC3, 1'b1, 2, 1'b0, 20);
        bus_cycle(0, 23'h001234, 8'h11, 1'b1, 1, 1'b0, 1);
        bus_cycle(1, 23'h001234, 8'h99, 1'b0, 1, 1'b0, 5);
        bus_cycle(0, 23'h001234, 8'h00, 1'b0, 2, 1'b0, 0);

        bus_cycle(0, 23'h000777, 8'h00, 1'b1, 0, 1'b0, 1);
        chk("timeout_err_set", 32'(timeout_err), 32'h1);
        bus_cycle(0, 23'h000778, 8'h00, 1'b1, 2, 1'b0, 1);
        chk("timeout_err_sticky", 32'(timeout_err), 32'h1);

        bus_cycle(0, 23'h000779, 8'h00, 1'b1, 5, 1'b1, 0);
        bus_cycle(2, 23'h00077A, 8'h44, 1'b1, 3, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            a = 23'h100000 + 23'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            bus_cycle((r < 5) ? 0 : 1, a, 8'($urandom), (r < 9), $urandom_range(1, 6),
                      1'b0, $urandom_range(0, 3));
        end

        sb_flush = 1'b1;
        resp_en = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        cart_ena = 1'b1; mem_addr = 23'h0ABCDE; rd_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_req", 32'(mem_req), 32'h1);
        reset = 1'b1; rd_n = 1'b1; cart_ena = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_wait_n", 32'(wait_n), 32'h1);
        chk("reset_timeout_err", 32'(timeout_err), 32'h0);
        chk("reset_cdout", 32'(cdout), 32'hFF);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("late_ack_req", 32'(mem_req), 32'h0);
        chk("late_ack_wait", 32'(wait_n), 32'h1);
        chk("late_ack_cdout", 32'(cdout), 32'hFF);
        resp_en = 1'b1;
        @(posedge clk); #1;
        sb_flush = 1'b0;
        bus_cycle(0, 23'h420123, 8'h00, 1'b1, 2, 1'b0, 1);

        repeat (4) begin @(posedge clk); #1; end
        chk("txn_q_drained", 32'(txn_q.size()), 32'h0);
        chk("data_q_drained", 32'(data_q.size()), 32'h0);
        chk("req_count", 32'(req_rises), 32'(exp_reqs));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
